os_inst_sequencer: RTL
======================

// Module: os_inst_sequencer
// PURPOSE
//   Hardware replacement for the bench-driven output-stationary instruction stream.
//   On start, issues the 49-bit core inst word: xmem->L0 fill, wmem->IFIFO fill, execute, flush.
//   Then drains os_out_array one PE row per beat over a valid/ready port.
//   Sits between the host/control logic and core (inst, os_out_array).
// PARAMETERS
//   ROW      8   PE rows; number of drain beats
//   COL      8   PE columns; lanes per drain beat
//   PSUM_BW  16  psum width per lane
//   ADDR_W   11  SRAM address width (xmem/wmem)
//   GAP_CYC  10  idle cycles between phases
//   FLUSH_CYC 50 cycles after execute before drain
// PORTS
//   clk           in   1                  clock, rising edge
//   reset         in   1                  asynchronous, active-high
//   start         in   1                  one-cycle request; honoured only when idle
//   cfg_len       in   ADDR_W             vectors per operand (e.g. 27)
//   cfg_xbase     in   ADDR_W             xmem start address
//   cfg_wbase     in   ADDR_W             wmem start address
//   cfg_relu      in   1                  driven onto inst[47]
//   inst          out  49                 core instruction word, registered
//   os_out_array  in   PSUM_BW*COL*ROW    core OS result array; row r at [r*COL*PSUM_BW +: COL*PSUM_BW]
//   out_data      out  PSUM_BW*COL        drained row, registered
//   out_valid     out  1                  out_data valid
//   out_ready     in   1                  consumer accept
//   out_row       out  $clog2(ROW)        row index of out_data
//   busy          out  1                  high in any state except IDLE
//   done          out  1                  one-cycle pulse at end of sequence
// BEHAVIOUR
//   Inst map: 48 mode=1, 47 relu, 46 acc=0, 45 CEN_w, 44 WEN_w, 43:33 A_w, 32 CEN_p,
//     31 WEN_p, 30:20 A_p, 19 CEN_x, 18 WEN_x, 17:7 A_x, 6 ofifo_rd, 5 ififo_wr,
//     4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load.
//     Idle word = 49'h1_3001_800C_0000 (all CEN/WEN=1, mode=1, rest 0).
//   Reset: inst=idle word, out_valid=0, out_data=0, out_row=0, busy=0, done=0, FSM=IDLE.
//   cfg_* latched on the accepted start. Later cfg changes have no effect until the next start.
//   States: IDLE -> XFILL -> GAP1 -> WFILL -> GAP2 -> EXEC -> FLUSH -> DRAIN -> DONE -> IDLE.
//   XFILL: LEN+1 cycles.
//     Cycles 0..LEN-1: CEN_x=0, WEN_x=1, A_x=xbase+k.
//     Cycles 1..LEN: l0_wr=1 (SRAM has 1-cycle read latency).
//   WFILL: identical on wmem, with ififo_wr in place of l0_wr.
//   GAP1/GAP2: GAP_CYC cycles of the idle word.
//   EXEC: LEN+1 cycles; l0_rd=ififo_rd=execute=1.
//   FLUSH: FLUSH_CYC cycles of the idle word.
//   DRAIN: out_data=os_out_array row out_row, out_valid=1.
//     On out_valid&out_ready, out_row advances.
//     Handshake on row ROW-1 -> DONE.
//     When out_ready=0: out_data and out_row held stable.
//   DONE: done=1 for one cycle; busy drops in the following IDLE cycle.
//   Address arithmetic is mod 2^ADDR_W; base+k wraps silently.
//   cfg_len==0: start -> DONE directly. No inst activity, no drain beats.
//   start while busy: ignored, no queueing. Start accepted in DONE's following IDLE cycle is legal.
//   reset mid-sequence: immediate abort, all outputs at reset values. No partial drain resumes.
// CONFIGURATION
//   OS_RELU_DRAIN_EN defined:
//     Each PSUM_BW lane of out_data is clamped to 0 when its MSB is 1 and cfg_relu=1.
//   OS_RELU_DRAIN_EN undefined:
//     Lanes pass raw (signed). cfg_relu only drives inst[47].
// TESTING
//   T1 reset: assert reset mid-EXEC -> inst=49'h1_3001_800C_0000, busy=0, out_valid=0 same cycle.
//   T2 fill: start, len=27, xbase=0 -> A_x 0..26 over 27 cycles, CEN_x=0; l0_wr high 27 cycles lagging 1.
//   T3 exec: len=27 -> execute/l0_rd/ififo_rd high exactly 28 cycles; FLUSH exactly 50 cycles.
//   T4 drain: out_ready=1 -> 8 beats, out_row 0..7, row r = os_out_array[r*128 +: 128]; done 1 cycle later.
//   T5 stall: out_ready=0 for 5 cycles at row 3 -> out_data/out_row held; start pulsed while busy is ignored.
//   T6 edges: len=0 -> done next cycle, no drain. xbase=2046, len=4 -> A_x 2046,2047,0,1.
//     With OS_RELU_DRAIN_EN and cfg_relu=1: lane 16'hFFF0 -> 0.

Source files
------------

// File: rtl/os_inst_sequencer.sv
// os_inst_sequencer: generates the output-stationary core instruction stream
// (xmem->L0 fill, wmem->IFIFO fill, execute, flush) and then drains the PE
// result array one row per beat over a valid/ready port.
// Optional feature macro: OS_RELU_DRAIN_EN (clamps negative drained lanes to 0
// when the latched relu bit is set).
module os_inst_sequencer #(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int PSUM_BW   = 16,
    parameter int ADDR_W    = 11,
    parameter int GAP_CYC   = 10,
    parameter int FLUSH_CYC = 50
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            cfg_len,
    input  logic [ADDR_W-1:0]            cfg_xbase,
    input  logic [ADDR_W-1:0]            cfg_wbase,
    input  logic                         cfg_relu,
    output logic [48:0]                  inst,
    input  logic [PSUM_BW*COL*ROW-1:0]   os_out_array,
    output logic [PSUM_BW*COL-1:0]       out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(ROW)-1:0]       out_row,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   o_dbg_state
);

    localparam int          RW        = PSUM_BW * COL;
    localparam int          RIDX_W    = $clog2(ROW);
    localparam int          CNT_W     = ADDR_W + 8;
    localparam logic [48:0] IDLE_WORD = 49'h1_3001_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_XFILL, S_GAP1, S_WFILL, S_GAP2, S_EXEC, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_xbase;
    logic [ADDR_W-1:0]   r_wbase;
    logic                r_relu;
    logic [48:0]         r_inst;
    logic [RW-1:0]       r_out_data;
    logic                r_out_valid;
    logic [RIDX_W-1:0]   r_out_row;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    w_len_ext;

    assign w_len_ext   = CNT_W'(r_len);
    assign inst        = r_inst;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_row     = r_out_row;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

    // Instruction word for cycle k of a phase. SRAM reads have one cycle of
    // latency, so the consumer write strobe (l0_wr / ififo_wr) lags the SRAM
    // read by one cycle: reads on k=0..len-1, writes on k=1..len.
    function automatic logic [48:0] f_inst(input state_t st, input logic [CNT_W-1:0] k,
                                           input logic [ADDR_W-1:0] len,
                                           input logic [ADDR_W-1:0] xb,
                                           input logic [ADDR_W-1:0] wb,
                                           input logic relu);
        logic [48:0]      w_word;
        logic [CNT_W-1:0] w_len_k;
        w_word  = IDLE_WORD;
        w_len_k = CNT_W'(len);
        case (st)
            S_XFILL: begin
                w_word[47] = relu;
                if (k < w_len_k) begin
                    w_word[19]   = 1'b0;
                    w_word[17:7] = xb + k[ADDR_W-1:0];
                end
                if (k != '0) w_word[2] = 1'b1;
            end
            S_WFILL: begin
                w_word[47] = relu;
                if (k < w_len_k) begin
                    w_word[45]    = 1'b0;
                    w_word[43:33] = wb + k[ADDR_W-1:0];
                end
                if (k != '0) w_word[5] = 1'b1;
            end
            S_EXEC: begin
                w_word[47] = relu;
                w_word[4]  = 1'b1;
                w_word[3]  = 1'b1;
                w_word[1]  = 1'b1;
            end
            default: w_word = IDLE_WORD;
        endcase
        return w_word;
    endfunction

    // One drained row, optionally with negative lanes clamped to zero.
    function automatic logic [RW-1:0] f_drain(input logic [RIDX_W-1:0] idx);
        logic [RW-1:0] w_row;
        w_row = os_out_array[int'(idx)*RW +: RW];
`ifdef OS_RELU_DRAIN_EN
        if (r_relu) begin
            for (int l = 0; l < COL; l++) begin
                if (w_row[l*PSUM_BW + PSUM_BW - 1]) w_row[l*PSUM_BW +: PSUM_BW] = '0;
            end
        end
`endif
        return w_row;
    endfunction

    // Sequencer FSM. Every output is registered and computed for the state being
    // entered, so inst lines up with the phase cycle counter.
    // Drain handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low,
    // out_data and out_row stay unchanged; out_valid never drops without a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_xbase     <= '0;
            r_wbase     <= '0;
            r_relu      <= 1'b0;
            r_inst      <= IDLE_WORD;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= cfg_len;
                        r_xbase <= cfg_xbase;
                        r_wbase <= cfg_wbase;
                        r_relu  <= cfg_relu;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        if (cfg_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_XFILL;
                            r_inst  <= f_inst(S_XFILL, '0, cfg_len, cfg_xbase, cfg_wbase, cfg_relu);
                        end
                    end
                end
                S_XFILL: begin
                    if (r_cnt == w_len_ext) begin
                        r_state <= S_GAP1;
                        r_cnt   <= '0;
                        r_inst  <= IDLE_WORD;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_inst <= f_inst(S_XFILL, r_cnt + 1'b1, r_len, r_xbase, r_wbase, r_relu);
                    end
                end
                S_GAP1: begin
                    if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                        r_state <= S_WFILL;
                        r_cnt   <= '0;
                        r_inst  <= f_inst(S_WFILL, '0, r_len, r_xbase, r_wbase, r_relu);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WFILL: begin
                    if (r_cnt == w_len_ext) begin
                        r_state <= S_GAP2;
                        r_cnt   <= '0;
                        r_inst  <= IDLE_WORD;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_inst <= f_inst(S_WFILL, r_cnt + 1'b1, r_len, r_xbase, r_wbase, r_relu);
                    end
                end
                S_GAP2: begin
                    if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                        r_state <= S_EXEC;
                        r_cnt   <= '0;
                        r_inst  <= f_inst(S_EXEC, '0, r_len, r_xbase, r_wbase, r_relu);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == w_len_ext) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= '0;
                        r_inst  <= IDLE_WORD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == CNT_W'(FLUSH_CYC - 1)) begin
                        r_state     <= S_DRAIN;
                        r_cnt       <= '0;
                        r_out_row   <= '0;
                        r_out_data  <= f_drain('0);
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_row == RIDX_W'(ROW - 1)) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_out_row  <= r_out_row + 1'b1;
                            r_out_data <= f_drain(r_out_row + 1'b1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_inst  <= IDLE_WORD;
                end
            endcase
        end
    end

endmodule
